// File: rtl/iir_ctrl_pkg.sv
// Shared definitions for the IIR coefficient controller: register map,
// coefficient width and controller states.
package iir_ctrl_pkg;

   localparam int unsigned COEF_W   = 32;
   localparam int unsigned NUM_COEF = 13;

   typedef logic [COEF_W-1:0] coef_t;

   localparam logic [3:0] ADDR_B1    = 4'd0;
   localparam logic [3:0] ADDR_B2    = 4'd1;
   localparam logic [3:0] ADDR_B3    = 4'd2;
   localparam logic [3:0] ADDR_B4    = 4'd3;
   localparam logic [3:0] ADDR_B5    = 4'd4;
   localparam logic [3:0] ADDR_B6    = 4'd5;
   localparam logic [3:0] ADDR_B7    = 4'd6;
   localparam logic [3:0] ADDR_A2    = 4'd7;
   localparam logic [3:0] ADDR_A3    = 4'd8;
   localparam logic [3:0] ADDR_A4    = 4'd9;
   localparam logic [3:0] ADDR_A5    = 4'd10;
   localparam logic [3:0] ADDR_A6    = 4'd11;
   localparam logic [3:0] ADDR_A7    = 4'd12;
   localparam logic [3:0] ADDR_SCALE = 4'd13;

   typedef enum logic [1:0] {
      ST_IDLE      = 2'd0,
      ST_RUN       = 2'd1,
      ST_WAIT_DONE = 2'd2
   } ctrl_state_e;

endpackage

// File: rtl/iir_coeff_bank.sv
// Double-buffered coefficient store: host writes land in the shadow bank,
// swap_i copies the whole shadow bank into the active bank in one cycle.
module iir_coeff_bank
   import iir_ctrl_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic       wr_i,
   input  logic [3:0] addr_i,
   input  coef_t      data_i,
   input  logic       swap_i,
   output coef_t      coef_o [NUM_COEF],
   output logic [2:0] scale_o
);

   coef_t      shadow_q [NUM_COEF];
   coef_t      shadow_d [NUM_COEF];
   coef_t      active_q [NUM_COEF];
   coef_t      active_d [NUM_COEF];
   logic [2:0] sh_scale_q, sh_scale_d;
   logic [2:0] act_scale_q, act_scale_d;

   always_comb begin
      shadow_d    = shadow_q;
      active_d    = active_q;
      sh_scale_d  = sh_scale_q;
      act_scale_d = act_scale_q;
      // Addresses 14 and 15 match nothing and are silently discarded.
      for (int unsigned i = 0; i < NUM_COEF; i++) begin
         if (wr_i && addr_i == 4'(i)) shadow_d[i] = data_i;
      end
      if (wr_i && addr_i == ADDR_SCALE) sh_scale_d = data_i[2:0];
      if (swap_i) begin
         active_d    = shadow_q;
         act_scale_d = sh_scale_q;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int unsigned i = 0; i < NUM_COEF; i++) begin
            shadow_q[i] <= '0;
            active_q[i] <= '0;
         end
         sh_scale_q  <= '0;
         act_scale_q <= '0;
      end else begin
         shadow_q    <= shadow_d;
         active_q    <= active_d;
         sh_scale_q  <= sh_scale_d;
         act_scale_q <= act_scale_d;
      end
   end

   assign coef_o  = active_q;
   assign scale_o = act_scale_q;

endmodule

// File: rtl/iir_coeff_ctrl.sv
// Sample sequencer for an external IIR filter: starts one filter run per
// sample strobe, captures the result, and swaps coefficients only when idle.
module iir_coeff_ctrl
   import iir_ctrl_pkg::*;
#(
   parameter int unsigned TIMEOUT = 31
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        cfg_wr,
   input  logic [3:0]  cfg_addr,
   input  logic [31:0] cfg_data,
   input  logic        cfg_commit,
   output logic        cfg_busy,
   input  logic        sample_strobe,
   output logic        filt_data_val,
   output logic [31:0] b1, b2, b3, b4, b5, b6, b7,
   output logic [31:0] a2, a3, a4, a5, a6, a7,
   output logic [2:0]  scale,
   input  logic [31:0] filt_out,
   input  logic        filt_out_val,
   output logic [31:0] sample_out,
   output logic        sample_out_val,
   output logic        overrun,
   output logic        timeout,
   input  logic        flag_clr
);

   localparam int unsigned CNT_W = $clog2(TIMEOUT + 2);

   ctrl_state_e state_q, state_d;
   logic             pending_q, pending_d;
   logic             strobe_q, strobe_d;
   logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
   logic [31:0]      sample_q, sample_d;
   logic             sval_q, sval_d;
   logic             overrun_q, overrun_d;
   logic             timeout_q, timeout_d;
   logic             swap, start, strobe_ok, overrun_set, timeout_set;
   coef_t            coef [NUM_COEF];

   assign cnt_inc   = cnt_q + CNT_W'(1);
   assign strobe_ok = (state_q == ST_IDLE) && !strobe_q;

   always_comb begin
      state_d     = state_q;
      pending_d   = pending_q | cfg_commit;
      strobe_d    = strobe_q | (sample_strobe & strobe_ok);
      cnt_d       = cnt_q;
      sample_d    = sample_q;
      sval_d      = 1'b0;
      swap        = 1'b0;
      start       = 1'b0;
      overrun_set = sample_strobe & ~strobe_ok;
      timeout_set = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            // A pending swap beats a queued strobe; the strobe waits one cycle.
            if (pending_q) begin
               swap      = 1'b1;
               pending_d = 1'b0;
            end else if (strobe_q) begin
               start    = 1'b1;
               strobe_d = 1'b0;
               cnt_d    = '0;
               state_d  = ST_RUN;
            end
         end
         ST_RUN: begin
            cnt_d = cnt_inc;
            if (filt_out_val) begin
               sample_d = filt_out;
               sval_d   = 1'b1;
               state_d  = ST_WAIT_DONE;
            end else if (cnt_inc == CNT_W'(TIMEOUT)) begin
               timeout_set = 1'b1;
               state_d     = ST_IDLE;
            end
         end
         ST_WAIT_DONE: state_d = ST_IDLE;
         default:      state_d = ST_IDLE;
      endcase
      overrun_d = flag_clr ? 1'b0 : (overrun_q | overrun_set);
      timeout_d = flag_clr ? 1'b0 : (timeout_q | timeout_set);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= ST_IDLE;
         pending_q <= 1'b0;
         strobe_q  <= 1'b0;
         cnt_q     <= '0;
         sample_q  <= '0;
         sval_q    <= 1'b0;
         overrun_q <= 1'b0;
         timeout_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         pending_q <= pending_d;
         strobe_q  <= strobe_d;
         cnt_q     <= cnt_d;
         sample_q  <= sample_d;
         sval_q    <= sval_d;
         overrun_q <= overrun_d;
         timeout_q <= timeout_d;
      end
   end

   iir_coeff_bank u_bank (
      .clk     (clk),
      .rst     (rst),
      .wr_i    (cfg_wr & ~pending_q),
      .addr_i  (cfg_addr),
      .data_i  (cfg_data),
      .swap_i  (swap),
      .coef_o  (coef),
      .scale_o (scale)
   );

   assign b1 = coef[ADDR_B1];
   assign b2 = coef[ADDR_B2];
   assign b3 = coef[ADDR_B3];
   assign b4 = coef[ADDR_B4];
   assign b5 = coef[ADDR_B5];
   assign b6 = coef[ADDR_B6];
   assign b7 = coef[ADDR_B7];
   assign a2 = coef[ADDR_A2];
   assign a3 = coef[ADDR_A3];
   assign a4 = coef[ADDR_A4];
   assign a5 = coef[ADDR_A5];
   assign a6 = coef[ADDR_A6];
   assign a7 = coef[ADDR_A7];

   assign cfg_busy       = pending_q;
   assign filt_data_val  = start;
   assign sample_out     = sample_q;
   assign sample_out_val = sval_q;
   assign overrun        = overrun_q;
   assign timeout        = timeout_q;

endmodule

// File: tb/tb_iir_coeff_ctrl.sv
// Bench for iir_coeff_ctrl: randomized config/sample traffic against an
// array-based register model and a stand-in filter with variable latency.
module tb_iir_coeff_ctrl;

   localparam int unsigned TMO = 31;

   logic        clk = 1'b0;
   logic        rst;
   logic        cfg_wr, cfg_commit, sample_strobe, flag_clr;
   logic [3:0]  cfg_addr;
   logic [31:0] cfg_data;
   logic        cfg_busy, filt_data_val, sample_out_val, overrun, timeout;
   logic [31:0] b1, b2, b3, b4, b5, b6, b7, a2, a3, a4, a5, a6, a7;
   logic [2:0]  scale;
   logic [31:0] filt_out, sample_out;
   logic        filt_out_val;
   wire  [31:0] dut_coef [13];

   always #5 clk = ~clk;

   iir_coeff_ctrl #(.TIMEOUT(TMO)) dut (
      .clk(clk), .rst(rst),
      .cfg_wr(cfg_wr), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
      .cfg_commit(cfg_commit), .cfg_busy(cfg_busy),
      .sample_strobe(sample_strobe), .filt_data_val(filt_data_val),
      .b1(b1), .b2(b2), .b3(b3), .b4(b4), .b5(b5), .b6(b6), .b7(b7),
      .a2(a2), .a3(a3), .a4(a4), .a5(a5), .a6(a6), .a7(a7),
      .scale(scale),
      .filt_out(filt_out), .filt_out_val(filt_out_val),
      .sample_out(sample_out), .sample_out_val(sample_out_val),
      .overrun(overrun), .timeout(timeout), .flag_clr(flag_clr)
   );

   assign dut_coef[0]  = b1;
   assign dut_coef[1]  = b2;
   assign dut_coef[2]  = b3;
   assign dut_coef[3]  = b4;
   assign dut_coef[4]  = b5;
   assign dut_coef[5]  = b6;
   assign dut_coef[6]  = b7;
   assign dut_coef[7]  = a2;
   assign dut_coef[8]  = a3;
   assign dut_coef[9]  = a4;
   assign dut_coef[10] = a5;
   assign dut_coef[11] = a6;
   assign dut_coef[12] = a7;

   int unsigned n_checks = 0;
   int unsigned n_errors = 0;

   // Register model: index 0..12 coefficients, 13 = scale.
   logic [31:0] sh  [14];
   logic [31:0] act [14];

   logic        filt_en  = 1'b0;
   int unsigned filt_lat = 1;
   logic [31:0] audio_x  = '0;
   int unsigned sov_count = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   // Stand-in filter: y = x * b1 in 2.30 with one guard bit, then >> scale.
   function automatic logic [31:0] filt_fn(input logic [31:0] b, input logic [31:0] x,
                                           input logic [2:0] s);
      longint p;
      p = longint'($signed(b)) * longint'($signed(x));
      p = p >>> 31;
      p = p >>> s;
      return p[31:0];
   endfunction

   initial begin
      logic [31:0] y;
      filt_out_val = 1'b0;
      filt_out     = '0;
      forever begin
         @(negedge clk);
         if (filt_data_val && filt_en) begin
            y = filt_fn(b1, audio_x, scale);
            repeat (filt_lat) @(posedge clk);
            #2 filt_out = y; filt_out_val = 1'b1;
            @(posedge clk);
            #2 filt_out_val = 1'b0; filt_out = $urandom;
         end
      end
   end

   always @(negedge clk) if (sample_out_val) sov_count++;

   initial begin
      #1000000;
      $display("FAIL watchdog expired checks=%0d", n_checks);
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic model_reset();
      for (int i = 0; i < 14; i++) begin
         sh[i]  = '0;
         act[i] = '0;
      end
   endtask

   task automatic model_write(input logic [3:0] a, input logic [31:0] d);
      if (a < 4'd13) sh[a] = d;
      else if (a == 4'd13) sh[13] = {29'd0, d[2:0]};
   endtask

   task automatic chk_coefs(input string tag);
      for (int i = 0; i < 13; i++) chk($sformatf("%s_c%0d", tag, i), dut_coef[i], act[i]);
      chk({tag, "_scale"}, {29'd0, scale}, act[13]);
   endtask

   task automatic wr(input logic [3:0] a, input logic [31:0] d);
      cfg_wr = 1'b1; cfg_addr = a; cfg_data = d;
      tick();
      cfg_wr = 1'b0;
      model_write(a, d);
   endtask

   task automatic commit(input string tag);
      cfg_commit = 1'b1;
      tick();
      cfg_commit = 1'b0;
      chk({tag, "_busy1"}, {31'd0, cfg_busy}, 32'd1);
      chk({tag, "_b1_old"}, b1, act[0]);
      tick();
      for (int i = 0; i < 14; i++) act[i] = sh[i];
      chk({tag, "_busy0"}, {31'd0, cfg_busy}, 32'd0);
      chk_coefs(tag);
   endtask

   // Called in the filt_data_val cycle; result valid lat+1 cycles later.
   task automatic wait_result(input string tag, input logic [31:0] exp, input int unsigned lat);
      int unsigned cyc;
      logic        got;
      cyc = 0;
      got = 1'b0;
      while (!got && cyc < 60) begin
         tick();
         cyc++;
         got = sample_out_val;
      end
      chk({tag, "_sval"}, {31'd0, got}, 32'd1);
      chk({tag, "_lat"}, cyc, lat + 1);
      chk({tag, "_out"}, sample_out, exp);
      tick();
      chk({tag, "_sval_drop"}, {31'd0, sample_out_val}, 32'd0);
   endtask

   task automatic run_sample(input string tag, input logic [31:0] x, input int unsigned lat);
      audio_x = x; filt_lat = lat; filt_en = 1'b1;
      sample_strobe = 1'b1;
      tick();
      sample_strobe = 1'b0;
      chk({tag, "_fdv"}, {31'd0, filt_data_val}, 32'd1);
      wait_result(tag, filt_fn(act[0], x, act[13][2:0]), lat);
   endtask

   initial begin
      int unsigned base;
      logic [31:0] keep;
      rst = 1'b1; cfg_wr = 1'b0; cfg_addr = '0; cfg_data = $urandom;
      cfg_commit = 1'b0; sample_strobe = 1'b0; flag_clr = 1'b0;
      model_reset();
      repeat (3) tick();
      rst = 1'b0;
      chk("rst_fdv", {31'd0, filt_data_val}, 32'd0);
      chk("rst_busy", {31'd0, cfg_busy}, 32'd0);
      chk("rst_sout", sample_out, 32'd0);
      chk("rst_sval", {31'd0, sample_out_val}, 32'd0);
      chk("rst_ovr", {31'd0, overrun}, 32'd0);
      chk("rst_tmo", {31'd0, timeout}, 32'd0);
      chk_coefs("rst");

      // Unity b1: coefficients visible before the start pulse; 0x10000 -> 0x8000.
      wr(4'd0, 32'h4000_0000);
      commit("unity");
      chk("unity_fdv_pre", {31'd0, filt_data_val}, 32'd0);
      run_sample("unity", 32'h0001_0000, 3);
      chk("unity_const", sample_out, 32'h0000_8000);

      for (int n = 0; n < 12; n++) begin
         int unsigned nw;
         nw = $urandom_range(1, 4);
         for (int k = 0; k < int'(nw); k++) wr(4'($urandom_range(0, 15)), $urandom);
         if ($urandom_range(0, 3) != 0) commit($sformatf("rnd%0d", n));
         else chk_coefs($sformatf("rnd%0d_nocommit", n));
         run_sample($sformatf("rnd%0d", n), $urandom, $urandom_range(1, 8));
      end
      chk("rnd_ovr", {31'd0, overrun}, 32'd0);
      chk("rnd_tmo", {31'd0, timeout}, 32'd0);

      // Commit and strobe together: swap first, start pulse two cycles later.
      wr(4'd0, $urandom);
      wr(4'd13, $urandom);
      audio_x = $urandom; filt_lat = 2; filt_en = 1'b1;
      cfg_commit = 1'b1; sample_strobe = 1'b1;
      tick();
      cfg_commit = 1'b0; sample_strobe = 1'b0;
      chk("both_fdv1", {31'd0, filt_data_val}, 32'd0);
      chk("both_busy", {31'd0, cfg_busy}, 32'd1);
      chk("both_b1_old", b1, act[0]);
      tick();
      for (int i = 0; i < 14; i++) act[i] = sh[i];
      chk("both_fdv2", {31'd0, filt_data_val}, 32'd1);
      chk_coefs("both");
      wait_result("both", filt_fn(act[0], audio_x, act[13][2:0]), 2);

      // Second strobe mid-run: overrun, exactly one result.
      base = sov_count;
      audio_x = $urandom; filt_lat = 8;
      sample_strobe = 1'b1;
      tick();
      sample_strobe = 1'b0;
      repeat (4) tick();
      sample_strobe = 1'b1;
      tick();
      sample_strobe = 1'b0;
      chk("ovr_set", {31'd0, overrun}, 32'd1);
      repeat (20) tick();
      chk("ovr_one_result", sov_count - base, 32'd1);
      chk("ovr_out", sample_out, filt_fn(act[0], audio_x, act[13][2:0]));
      flag_clr = 1'b1;
      tick();
      flag_clr = 1'b0;
      chk("ovr_clr", {31'd0, overrun}, 32'd0);

      // flag_clr wins over a coincident overrun.
      filt_lat = 4;
      sample_strobe = 1'b1;
      tick();
      sample_strobe = 1'b0;
      tick();
      sample_strobe = 1'b1; flag_clr = 1'b1;
      tick();
      sample_strobe = 1'b0; flag_clr = 1'b0;
      chk("clr_prio", {31'd0, overrun}, 32'd0);
      repeat (10) tick();

      // Silent filter: timeout after 31 run cycles, next strobe accepted.
      base = sov_count;
      filt_en = 1'b0;
      sample_strobe = 1'b1;
      tick();
      sample_strobe = 1'b0;
      chk("tmo_fdv", {31'd0, filt_data_val}, 32'd1);
      repeat (TMO) tick();
      chk("tmo_before", {31'd0, timeout}, 32'd0);
      tick();
      chk("tmo_set", {31'd0, timeout}, 32'd1);
      chk("tmo_no_result", sov_count - base, 32'd0);
      chk("tmo_no_ovr", {31'd0, overrun}, 32'd0);
      run_sample("tmo_next", $urandom, 5);
      flag_clr = 1'b1;
      tick();
      flag_clr = 1'b0;
      chk("tmo_clr", {31'd0, timeout}, 32'd0);

      // Writes while busy are dropped; addresses 14/15 change nothing.
      keep = $urandom;
      wr(4'd0, keep);
      cfg_commit = 1'b1;
      tick();
      cfg_commit = 1'b0;
      cfg_wr = 1'b1; cfg_addr = 4'd0; cfg_data = ~keep;
      tick();
      cfg_wr = 1'b0;
      for (int i = 0; i < 14; i++) act[i] = sh[i];
      chk("busy_b1", b1, keep);
      commit("busy_recommit");
      chk("busy_shadow_b1", b1, keep);
      wr(4'd14, $urandom);
      wr(4'd15, $urandom);
      commit("hole");

      // Reset three cycles into a run abandons the sample.
      base = sov_count;
      filt_en = 1'b1; filt_lat = 6; audio_x = $urandom;
      sample_strobe = 1'b1;
      tick();
      sample_strobe = 1'b0;
      repeat (3) tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      model_reset();
      chk("mrst_fdv", {31'd0, filt_data_val}, 32'd0);
      chk("mrst_sout", sample_out, 32'd0);
      chk("mrst_sval", {31'd0, sample_out_val}, 32'd0);
      chk("mrst_busy", {31'd0, cfg_busy}, 32'd0);
      chk_coefs("mrst");
      repeat (40) tick();
      chk("mrst_no_result", sov_count - base, 32'd0);
      chk("mrst_tmo", {31'd0, timeout}, 32'd0);
      chk("mrst_ovr", {31'd0, overrun}, 32'd0);
      chk("mrst_sout_after", sample_out, 32'd0);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
